// File: rtl/uart_fifo_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_fifo_core : buffered UART, TX/RX FIFOs, sticky errors, runtime baud.  |
// | Optional even parity enabled by defining UART_PARITY_EN.                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_fifo_core #(
   parameter int          DATA_BITS  = 8,
   parameter int          TX_DEPTH   = 8,
   parameter int          RX_DEPTH   = 8,
   parameter logic [31:0] RESET_BAUD = 32'd50
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        baud_we,
   input  logic [31:0]                 set_baud,
   output logic [31:0]                 get_baud,
   input  logic                        tx_we,
   input  logic [DATA_BITS-1:0]        tx_wdata,
   output logic                        tx_full,
   output logic [$clog2(TX_DEPTH):0]   tx_count,
   output logic                        tx_busy,
   input  logic                        rx_re,
   output logic [DATA_BITS-1:0]        rx_rdata,
   output logic                        rx_empty,
   output logic [$clog2(RX_DEPTH):0]   rx_count,
   output logic                        rx_overrun,
   output logic                        frame_err,
   output logic                        parity_err,
   input  logic                        clr_err,
   input  logic                        RX,
   output logic                        TX
);

   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam logic [TX_AW:0] c_TX_FULL  = (TX_AW+1)'(TX_DEPTH);
   localparam logic [RX_AW:0] c_RX_FULL  = (RX_AW+1)'(RX_DEPTH);
   localparam logic [2:0]     c_LAST_BIT = 3'(DATA_BITS-1);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_START  = 3'd1;
   localparam logic [2:0] c_DATA   = 3'd2;
   localparam logic [2:0] c_PARITY = 3'd3;
   localparam logic [2:0] c_STOP   = 3'd4;

`ifdef UART_PARITY_EN
   localparam logic c_PAR_EN = 1'b1;
`else
   localparam logic c_PAR_EN = 1'b0;
`endif

   // ---------------- baud register ----------------
   logic [31:0] r_baud;
   logic [31:0] w_baud_eff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_baud <= RESET_BAUD;
      else if (baud_we) r_baud <= set_baud;
   end

   assign get_baud   = r_baud;
   assign w_baud_eff = (r_baud < 32'd2) ? 32'd2 : r_baud;

   // ---------------- TX FIFO ----------------
   logic [DATA_BITS-1:0] r_tx_mem [TX_DEPTH];
   logic [TX_AW-1:0]     r_tx_wptr, r_tx_rptr;
   logic [TX_AW:0]       r_tx_count;
   logic                 w_tx_push, w_tx_pop;
   logic [DATA_BITS-1:0] w_tx_head;

   assign tx_full   = (r_tx_count == c_TX_FULL);
   assign tx_count  = r_tx_count;
   assign w_tx_push = tx_we && (!tx_full || w_tx_pop);
   assign w_tx_head = r_tx_mem[r_tx_rptr];

   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wptr] <= tx_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_wptr  <= '0;
         r_tx_rptr  <= '0;
         r_tx_count <= '0;
      end else begin
         if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
         if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
         if (w_tx_push && !w_tx_pop)      r_tx_count <= r_tx_count + 1'b1;
         else if (!w_tx_push && w_tx_pop) r_tx_count <= r_tx_count - 1'b1;
      end
   end

   // ---------------- TX engine ----------------
   logic [2:0]           r_tx_state, w_tx_state_nxt;
   logic [31:0]          r_tx_cnt, r_tx_period;
   logic [2:0]           r_tx_bit;
   logic [DATA_BITS-1:0] r_tx_shift;
   logic                 r_tx_par;
   logic                 r_tx_line, w_tx_line;
   logic                 r_tx_busy;
   logic                 w_tx_bit_end, w_tx_load;

   assign w_tx_bit_end = (r_tx_cnt == r_tx_period - 32'd1);
   // Every bit boundary restarts the counter and re-latches the baud period.
   assign w_tx_load    = (w_tx_state_nxt != r_tx_state) ||
                         ((r_tx_state == c_DATA) && w_tx_bit_end);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_tx_state <= c_IDLE;
      else        r_tx_state <= w_tx_state_nxt;
   end

   always_comb begin
      w_tx_state_nxt = r_tx_state;
      w_tx_pop       = 1'b0;
      case (r_tx_state)
         c_IDLE: if (r_tx_count != '0) begin
            w_tx_pop       = 1'b1;
            w_tx_state_nxt = c_START;
         end
         c_START:  if (w_tx_bit_end) w_tx_state_nxt = c_DATA;
         c_DATA:   if (w_tx_bit_end && (r_tx_bit == c_LAST_BIT))
                      w_tx_state_nxt = c_PAR_EN ? c_PARITY : c_STOP;
         c_PARITY: if (w_tx_bit_end) w_tx_state_nxt = c_STOP;
         c_STOP: if (w_tx_bit_end) begin
            if (r_tx_count != '0) begin
               w_tx_pop       = 1'b1;
               w_tx_state_nxt = c_START;
            end else begin
               w_tx_state_nxt = c_IDLE;
            end
         end
         default: w_tx_state_nxt = c_IDLE;
      endcase
   end

   always_comb begin
      w_tx_line = 1'b1;
      case (r_tx_state)
         c_START:  w_tx_line = 1'b0;
         c_DATA:   w_tx_line = r_tx_shift[0];
         c_PARITY: w_tx_line = r_tx_par;
         default:  w_tx_line = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_cnt    <= '0;
         r_tx_period <= 32'd2;
         r_tx_bit    <= '0;
         r_tx_shift  <= '0;
         r_tx_par    <= 1'b0;
         r_tx_line   <= 1'b1;
         r_tx_busy   <= 1'b0;
      end else begin
         if (w_tx_load) begin
            r_tx_cnt    <= '0;
            r_tx_period <= w_baud_eff;
         end else if (r_tx_state != c_IDLE) begin
            r_tx_cnt <= r_tx_cnt + 32'd1;
         end
         if (w_tx_pop) begin
            r_tx_shift <= w_tx_head;
            r_tx_par   <= ^w_tx_head;
            r_tx_bit   <= '0;
         end else if ((r_tx_state == c_DATA) && w_tx_bit_end) begin
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_bit   <= r_tx_bit + 3'd1;
         end
         r_tx_line <= w_tx_line;
         r_tx_busy <= (r_tx_state != c_IDLE) || (r_tx_count != '0);
      end
   end

   assign TX      = r_tx_line;
   assign tx_busy = r_tx_busy;

   // ---------------- RX engine ----------------
   logic                 r_rx_s1, r_rx_s2, r_rx_prev;
   logic [2:0]           r_rx_state, w_rx_state_nxt;
   logic [31:0]          r_rx_cnt, r_rx_period;
   logic [2:0]           r_rx_bit;
   logic [DATA_BITS-1:0] r_rx_shift;
   logic                 w_rx_fall, w_rx_half_end, w_rx_bit_end, w_rx_load;
   logic                 w_rx_stop_smp, w_rx_par_ok;
   logic                 w_rx_good, w_rx_frame_bad, w_rx_par_bad;
   logic                 w_rx_push, w_rx_pop, w_rx_ovr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_s1   <= 1'b1;
         r_rx_s2   <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_s1   <= RX;
         r_rx_s2   <= r_rx_s1;
         r_rx_prev <= r_rx_s2;
      end
   end

   assign w_rx_fall     = r_rx_prev && !r_rx_s2;
   assign w_rx_half_end = (r_rx_cnt == (r_rx_period >> 1) - 32'd1);
   assign w_rx_bit_end  = (r_rx_cnt == r_rx_period - 32'd1);
   assign w_rx_load     = (w_rx_state_nxt != r_rx_state) ||
                          ((r_rx_state == c_DATA) && w_rx_bit_end);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rx_state <= c_IDLE;
      else        r_rx_state <= w_rx_state_nxt;
   end

   always_comb begin
      w_rx_state_nxt = r_rx_state;
      case (r_rx_state)
         c_IDLE:   if (w_rx_fall) w_rx_state_nxt = c_START;
         c_START:  if (w_rx_half_end) w_rx_state_nxt = r_rx_s2 ? c_IDLE : c_DATA;
         c_DATA:   if (w_rx_bit_end && (r_rx_bit == c_LAST_BIT))
                      w_rx_state_nxt = c_PAR_EN ? c_PARITY : c_STOP;
         c_PARITY: if (w_rx_bit_end) w_rx_state_nxt = c_STOP;
         c_STOP:   if (w_rx_bit_end) w_rx_state_nxt = c_IDLE;
         default:  w_rx_state_nxt = c_IDLE;
      endcase
   end

   always_comb begin
      w_rx_stop_smp  = (r_rx_state == c_STOP) && w_rx_bit_end;
      w_rx_frame_bad = w_rx_stop_smp && !r_rx_s2;
      w_rx_par_bad   = w_rx_stop_smp && !w_rx_par_ok;
      w_rx_good      = w_rx_stop_smp && r_rx_s2 && w_rx_par_ok;
      w_rx_push      = w_rx_good && (!(rx_count == c_RX_FULL) || w_rx_pop);
      w_rx_ovr       = w_rx_good && (rx_count == c_RX_FULL) && !w_rx_pop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_cnt    <= '0;
         r_rx_period <= 32'd2;
         r_rx_bit    <= '0;
         r_rx_shift  <= '0;
      end else begin
         if (w_rx_load) begin
            r_rx_cnt    <= '0;
            r_rx_period <= w_baud_eff;
         end else if (r_rx_state != c_IDLE) begin
            r_rx_cnt <= r_rx_cnt + 32'd1;
         end
         if (r_rx_state == c_START) begin
            r_rx_bit <= '0;
         end else if ((r_rx_state == c_DATA) && w_rx_bit_end) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
         end
      end
   end

`ifdef UART_PARITY_EN
   logic r_rx_par_bit;
   logic r_parity_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_par_bit <= 1'b0;
         r_parity_err <= 1'b0;
      end else begin
         if ((r_rx_state == c_PARITY) && w_rx_bit_end) r_rx_par_bit <= r_rx_s2;
         if (w_rx_par_bad)  r_parity_err <= 1'b1;
         else if (clr_err)  r_parity_err <= 1'b0;
      end
   end

   // Even parity: data bits XOR parity bit must be zero.
   assign w_rx_par_ok = ((^r_rx_shift) == r_rx_par_bit);
   assign parity_err  = r_parity_err;
`else
   assign w_rx_par_ok = 1'b1;
   assign parity_err  = 1'b0;
`endif

   // ---------------- RX FIFO and sticky flags ----------------
   logic [DATA_BITS-1:0] r_rx_mem [RX_DEPTH];
   logic [RX_AW-1:0]     r_rx_wptr, r_rx_rptr;
   logic [RX_AW:0]       r_rx_count;
   logic                 r_rx_overrun, r_frame_err;

   assign rx_count = r_rx_count;
   assign rx_empty = (r_rx_count == '0);
   assign rx_rdata = rx_empty ? '0 : r_rx_mem[r_rx_rptr];
   assign w_rx_pop = rx_re && !rx_empty;

   always_ff @(posedge clk) begin
      if (w_rx_push) r_rx_mem[r_rx_wptr] <= r_rx_shift;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_wptr    <= '0;
         r_rx_rptr    <= '0;
         r_rx_count   <= '0;
         r_rx_overrun <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
         if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
         if (w_rx_push && !w_rx_pop)      r_rx_count <= r_rx_count + 1'b1;
         else if (!w_rx_push && w_rx_pop) r_rx_count <= r_rx_count - 1'b1;
         if (w_rx_ovr)      r_rx_overrun <= 1'b1;
         else if (clr_err)  r_rx_overrun <= 1'b0;
         if (w_rx_frame_bad) r_frame_err <= 1'b1;
         else if (clr_err)   r_frame_err <= 1'b0;
      end
   end

   assign rx_overrun = r_rx_overrun;
   assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_fifo_core : scoreboard bench for uart_fifo_core (TX decode, RX FIFO)|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_uart_fifo_core;

   localparam int BAUD = 50;
`ifdef UART_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FRAME = (1 + 8 + P + 1) * BAUD;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        baud_we;
   logic [31:0] set_baud;
   logic [31:0] get_baud;
   logic        tx_we;
   logic [7:0]  tx_wdata;
   logic        tx_full;
   logic [3:0]  tx_count;
   logic        tx_busy;
   logic        rx_re;
   logic [7:0]  rx_rdata;
   logic        rx_empty;
   logic [3:0]  rx_count;
   logic        rx_overrun;
   logic        frame_err;
   logic        parity_err;
   logic        clr_err;
   logic        rx_line;
   logic        tx_line;

   logic        loop_en;
   logic        rx_drv;
   logic        mon_en;
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic [7:0]  tx_exp[$];
   logic [7:0]  rx_exp[$];
   int          fall_q[$];

   assign rx_line = loop_en ? tx_line : rx_drv;

   uart_fifo_core #(
      .DATA_BITS(8), .TX_DEPTH(8), .RX_DEPTH(8), .RESET_BAUD(32'd50)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .baud_we(baud_we), .set_baud(set_baud), .get_baud(get_baud),
      .tx_we(tx_we), .tx_wdata(tx_wdata), .tx_full(tx_full),
      .tx_count(tx_count), .tx_busy(tx_busy),
      .rx_re(rx_re), .rx_rdata(rx_rdata), .rx_empty(rx_empty),
      .rx_count(rx_count), .rx_overrun(rx_overrun),
      .frame_err(frame_err), .parity_err(parity_err), .clr_err(clr_err),
      .RX(rx_line), .TX(tx_line)
   );

   always #5 clk = ~clk;
   always @(negedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic pop_rx();
      rx_re = 1'b1;
      @(negedge clk);
      rx_re = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while (tx_busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, tx_busy, 1'b0);
   endtask

   task automatic wait_rx_count(input int target, input int budget, input string tag);
      int n = 0;
      while (rx_count != 4'(target) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, rx_count, target);
   endtask

   // Bit-bang one frame onto RX at BAUD cycles per bit.
   task automatic send_rx(input logic [7:0] d, input logic stop_v, input logic par_flip);
      rx_drv = 1'b0;
      repeat (BAUD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         repeat (BAUD) @(negedge clk);
      end
      if (P == 1) begin
         rx_drv = (^d) ^ par_flip;
         repeat (BAUD) @(negedge clk);
      end
      rx_drv = stop_v;
      repeat (BAUD) @(negedge clk);
      rx_drv = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   // TX line decoder: samples mid-bit and checks against the expected queue.
   initial begin
      logic [7:0]  b;
      logic [31:0] e;
      forever begin
         @(negedge tx_line);
         if (mon_en && rst_n) begin
            fall_q.push_back(cyc);
            repeat (BAUD / 2) @(negedge clk);
            check("tx_start", tx_line, 1'b0);
            for (int i = 0; i < 8; i++) begin
               repeat (BAUD) @(negedge clk);
               b[i] = tx_line;
            end
            if (P == 1) begin
               repeat (BAUD) @(negedge clk);
               check("tx_parity", tx_line, ^b);
            end
            repeat (BAUD) @(negedge clk);
            check("tx_stop", tx_line, 1'b1);
            e = (tx_exp.size() > 0) ? {24'h0, tx_exp.pop_front()} : 32'hDEAD;
            check("tx_byte", b, e);
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int d;
      rst_n = 1'b0; tx_we = 1'b0; tx_wdata = '0; rx_re = 1'b0; clr_err = 1'b0;
      baud_we = 1'b0; set_baud = '0; loop_en = 1'b0; rx_drv = 1'b1; mon_en = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("rst_tx", tx_line, 1'b1);
      check("rst_tx_full", tx_full, 1'b0);
      check("rst_tx_count", tx_count, 0);
      check("rst_tx_busy", tx_busy, 1'b0);
      check("rst_rx_empty", rx_empty, 1'b1);
      check("rst_rx_count", rx_count, 0);
      check("rst_rx_rdata", rx_rdata, 0);
      check("rst_overrun", rx_overrun, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      check("rst_parity_err", parity_err, 1'b0);
      check("rst_baud", get_baud, 50);
      mon_en = 1'b1;

      // Single frame 0xA5 with start latency
      tx_we = 1'b1; tx_wdata = 8'hA5; tx_exp.push_back(8'hA5);
      @(negedge clk);
      tx_we = 1'b0;
      check("lat_busy_n0", tx_busy, 1'b0);
      check("lat_count_n0", tx_count, 1);
      check("lat_tx_n0", tx_line, 1'b1);
      @(negedge clk);
      check("lat_busy_n1", tx_busy, 1'b1);
      check("lat_tx_n1", tx_line, 1'b1);
      @(negedge clk);
      check("lat_tx_n2", tx_line, 1'b0);
      d = 0;
      while (tx_busy && d < 2 * FRAME) begin
         @(negedge clk);
         d++;
      end
      check("busy_drop_window", (d >= FRAME && d <= FRAME + 10), 1'b1);

      // Nine pushes into an 8-deep FIFO while idle, then one dropped push
      repeat (5) @(negedge clk);
      fall_q.delete();
      for (int i = 1; i <= 9; i++) begin
         tx_we = 1'b1; tx_wdata = 8'(i); tx_exp.push_back(8'(i));
         @(negedge clk);
      end
      tx_we = 1'b0;
      check("burst_full", tx_full, 1'b1);
      check("burst_count", tx_count, 8);
      tx_we = 1'b1; tx_wdata = 8'h0A;
      @(negedge clk);
      tx_we = 1'b0;
      check("burst_drop", tx_count, 8);
      wait_idle(10 * FRAME, "burst_idle");
      check("burst_frames", fall_q.size(), 9);
      for (int i = 1; i < 9 && i < fall_q.size(); i++)
         check("burst_gap", fall_q[i] - fall_q[i-1], FRAME);
      check("burst_txq", tx_exp.size(), 0);

      // Loopback two bytes
      loop_en = 1'b1;
      repeat (5) @(negedge clk);
      foreach (rx_exp[i]) rx_exp.delete(i);
      tx_we = 1'b1; tx_wdata = 8'h3C; tx_exp.push_back(8'h3C); rx_exp.push_back(8'h3C);
      @(negedge clk);
      tx_wdata = 8'hC3; tx_exp.push_back(8'hC3); rx_exp.push_back(8'hC3);
      @(negedge clk);
      tx_we = 1'b0;
      wait_rx_count(2, 4 * FRAME, "loop_count");
      check("loop_head0", rx_rdata, rx_exp.pop_front());
      pop_rx();
      check("loop_head1", rx_rdata, rx_exp.pop_front());
      pop_rx();
      check("loop_empty", rx_empty, 1'b1);
      check("loop_rdata0", rx_rdata, 0);
      pop_rx();
      check("loop_pop_empty", rx_count, 0);
      wait_idle(2 * FRAME, "loop_idle");

      // Overrun: nine frames into an 8-deep RX FIFO
      for (int i = 0; i < 9; i++) begin
         tx_we = 1'b1; tx_wdata = 8'(8'h10 + i); tx_exp.push_back(8'(8'h10 + i));
         if (i < 8) rx_exp.push_back(8'(8'h10 + i));
         @(negedge clk);
      end
      tx_we = 1'b0;
      wait_idle(12 * FRAME, "ovr_idle");
      repeat (20) @(negedge clk);
      check("ovr_flag", rx_overrun, 1'b1);
      check("ovr_count", rx_count, 8);
      check("ovr_head", rx_rdata, rx_exp[0]);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("ovr_clear", rx_overrun, 1'b0);
      for (int i = 0; i < 8; i++) begin
         check("ovr_drain", rx_rdata, rx_exp.pop_front());
         pop_rx();
      end
      check("ovr_drained", rx_empty, 1'b1);

      // Direct RX: glitch, good frame, framing error
      loop_en = 1'b0;
      rx_drv = 1'b0;
      repeat (10) @(negedge clk);
      rx_drv = 1'b1;
      repeat (FRAME + 50) @(negedge clk);
      check("glitch_empty", rx_empty, 1'b1);
      check("glitch_ferr", frame_err, 1'b0);
      check("glitch_ovr", rx_overrun, 1'b0);
      rx_exp.push_back(8'h5A);
      send_rx(8'h5A, 1'b1, 1'b0);
      check("rx_good_count", rx_count, 1);
      check("rx_good_data", rx_rdata, rx_exp.pop_front());
      pop_rx();
      send_rx(8'h33, 1'b0, 1'b0);
      check("ferr_flag", frame_err, 1'b1);
      check("ferr_empty", rx_empty, 1'b1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("ferr_clear", frame_err, 1'b0);

      // Baud change during the start bit of 0x55
      mon_en = 1'b0;
      tx_we = 1'b1; tx_wdata = 8'h55;
      @(negedge clk);
      tx_we = 1'b0;
      d = 0;
      while (tx_line !== 1'b0 && d < 100) begin
         @(negedge clk);
         d++;
      end
      check("bc_fall", tx_line, 1'b0);
      d = 0;
      do begin
         @(negedge clk);
         d++;
         if (d == 20) begin baud_we = 1'b1; set_baud = 32'd100; end
         if (d == 21) baud_we = 1'b0;
      end while (tx_line == 1'b0 && d < 300);
      check("bc_start_len", d, 50);
      check("bc_get_baud", get_baud, 100);
      d = 0;
      do begin
         @(negedge clk);
         d++;
      end while (tx_line == 1'b1 && d < 400);
      check("bc_bit0_len", d, 100);
      wait_idle(2 * FRAME * 2, "bc_idle");
      baud_we = 1'b1; set_baud = 32'd50;
      @(negedge clk);
      baud_we = 1'b0;
      mon_en = 1'b1;
      repeat (10) @(negedge clk);

`ifdef UART_PARITY_EN
      send_rx(8'h07, 1'b1, 1'b1);
      check("par_flag", parity_err, 1'b1);
      check("par_dropped", rx_empty, 1'b1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("par_clear", parity_err, 1'b0);
`else
      send_rx(8'h07, 1'b1, 1'b0);
      check("nopar_flag", parity_err, 1'b0);
      check("nopar_data", rx_rdata, 8'h07);
      pop_rx();
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_fifo_core.md
# uart_fifo_core

Parametrised, buffered UART for the SoC IO subsystem; next generation of the single-byte UART peripheral. Adds TX and RX FIFOs, configurable data-frame width, sticky overrun/framing error flags and optional parity, while keeping the run-time programmable baud period. Sits behind the memory-mapped IO decoder; the bus side sees push/pop strobes and status, the line side sees TX/RX pins.

## Interface
- DATA_BITS, 8, data bits per frame (5–8)
- TX_DEPTH, 8, TX FIFO entries (power of 2, ≥2)
- RX_DEPTH, 8, RX FIFO entries (power of 2, ≥2)
- RESET_BAUD, 50, baud period in clk cycles after reset

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- baud_we  in  1  load set_baud into baud register
- set_baud  in  32  new baud period (clk cycles per bit)
- get_baud  out  32  current baud register
- tx_we  in  1  push tx_wdata into TX FIFO
- tx_wdata  in  DATA_BITS  byte to transmit
- tx_full  out  1  TX FIFO full
- tx_count  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy
- tx_busy  out  1  frame on line or TX FIFO non-empty
- rx_re  in  1  pop RX FIFO head
- rx_rdata  out  DATA_BITS  RX FIFO head (show-ahead)
- rx_empty  out  1  RX FIFO empty
- rx_count  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy
- rx_overrun  out  1  sticky: frame dropped, RX FIFO full
- frame_err  out  1  sticky: stop bit sampled low
- parity_err  out  1  sticky: parity mismatch (see Configuration)
- clr_err  in  1  clear all sticky flags
- RX  in  1  serial input, asynchronous
- TX  out  1  serial output

## Operation
- Baud register: reset RESET_BAUD; baud_we loads set_baud; values <2 are used as 2. Engines latch the period at each bit start; a change applies from the next bit boundary.
- TX FIFO: tx_we when full is dropped, unless the engine pops in the same cycle (then accepted). Count never wraps.
- TX engine states IDLE→START→DATA→[PARITY]→STOP→IDLE. In IDLE with FIFO non-empty: pop head, enter START. Each state lasts one baud period. Data LSB first. At end of STOP, if FIFO non-empty, go directly to START (no idle gap).
- RX: 2-flop synchroniser on RX. States IDLE→START→DATA→[PARITY]→STOP. IDLE: falling edge → START; wait baud>>1 cycles, sample; high = false start → IDLE. Then sample each bit every baud period (mid-bit).
- STOP sample: low → set frame_err, discard byte. High and no parity error → push to RX FIFO; if full and no rx_re same cycle → discard, set rx_overrun. Either way → IDLE (re-arms on next falling edge).
- rx_re when empty ignored; rx_rdata is 0 when empty.
- clr_err together with a new error event: set wins.
- Reset mid-frame: engines abort to IDLE, FIFOs emptied, TX driven high immediately.

## Timing
- Reset values: TX=1, tx_full=0, tx_count=0, tx_busy=0, rx_empty=1, rx_count=0, rx_rdata=0, all error flags 0, get_baud=RESET_BAUD.
- All outputs registered except rx_rdata/status, which are decoded from registered FIFO state.
- tx_we at edge N into empty FIFO, engine idle: TX falls after edge N+2; tx_busy high after edge N+1.
- Frame length: (1+DATA_BITS+P+1)×baud cycles, P=1 with parity else 0.
- RX: byte visible (rx_empty=0) 1 cycle after STOP sample; STOP sample ≈ 2 + baud/2 + (DATA_BITS+P+1)×baud cycles after RX falls.

## Configuration
- UART_PARITY_EN defined: even parity bit after data on TX; RX checks it, mismatch sets parity_err and discards the byte.
- Undefined: no parity bit, frames are 8N1-style (DATA_BITS, N, 1); parity_err tied 0.

## Test plan
- Reset, baud=50, push 0xA5 → TX frame 0,1,0,1,0,0,1,0,1,1 at 50 cycles/bit, tx_busy drops after stop.
- Push 9 bytes 0x01..0x09 with TX_DEPTH=8 while idle → first 9 accepted (engine popped one), back-to-back frames no gap, tx_full seen.
- Loop TX→RX, send 0x3C,0xC3 → rx_count=2, rx_rdata=0x3C, rx_re → 0xC3, rx_re → rx_empty=1.
- Fill RX FIFO (8 bytes), send 9th with no pop → rx_overrun=1, count stays 8, head unchanged; clr_err → 0.
- Drive RX low 10 cycles (glitch, baud=50) → no byte, no error; drive frame with stop=0 → frame_err=1, rx_empty=1.
- baud_we 100 mid-frame → current bit keeps 50, subsequent bits 100; with UART_PARITY_EN, bad parity on 0x07 → parity_err=1, byte dropped.
